// File: rtl/ramio_if.sv
// ramio_if: word-wide req/ack port between the ramio request engine and
// its backing memory. The engine is the master; the memory is the slave.
interface ramio_if #(
  parameter int MEM_ADDR_WIDTH = 20
);
  logic                      mem_req;
  logic                      mem_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]               mem_wdata;
  logic [31:0]               mem_rdata;
  logic                      mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/ramio.sv
// ramio: turns byte/half/word load-store requests from the core into
// whole-word req/ack transactions (read-modify-write for sub-word stores),
// sign/zero-extends loads, and hosts the LED and UART-out I/O registers.
// Optional feature macro: RAMIO_UART_EN builds the 8N1 UART transmitter;
// without it uart_tx is tied high and UART register writes are dropped.
module ramio #(
  parameter int          MEM_ADDR_WIDTH = 20,
  parameter int          CLK_FREQ       = 27_000_000,
  parameter int          BAUD_RATE      = 115200,
  parameter logic [31:0] ADDR_LEDS      = 32'hFFFF_FFFF,
  parameter logic [31:0] ADDR_UART_OUT  = 32'hFFFF_FFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  write_type,
  input  logic [2:0]  read_type,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_ready,
  output logic        busy,
  output logic [5:0]  led,
  output logic        uart_tx,
  ramio_if.master     mem
);

  typedef enum logic [2:0] {
    IDLE, MEM_READ, MEM_WRITE, RMW_READ, RMW_WRITE, UART_SEND, DONE
  } state_t;

  state_t      state;
  logic [31:0] lat_addr;
  logic [2:0]  lat_rt;
  logic [1:0]  lat_wt;
  logic [31:0] lat_din;

  logic tuple_eq, type_nz, in_wr, in_ram, accept, lat_rd;

  // Lane extraction followed by sign/zero extension of a loaded word.
  function automatic logic [31:0] extend_read(input logic [31:0] w,
                                              input logic [2:0]  rt,
                                              input logic [1:0]  lane);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h  = lane[1] ? w[31:16] : w[15:0];
    bs = b;
    hs = h;
    case (rt[1:0])
      2'b01:   extend_read = rt[2] ? 32'(bs) : {24'b0, b};
      2'b10:   extend_read = rt[2] ? 32'(hs) : {16'b0, h};
      default: extend_read = w;
    endcase
  endfunction

  // Insert the store byte/half into the word read back from memory.
  function automatic logic [31:0] merge_store(input logic [31:0] w,
                                              input logic [31:0] d,
                                              input logic [1:0]  wt,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = w;
    if (wt == 2'b10) begin
      if (lane[1]) r[31:16] = d[15:0];
      else         r[15:0]  = d[15:0];
    end else begin
      case (lane)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end
    merge_store = r;
  endfunction

  assign tuple_eq = ({address, read_type, write_type, data_in} ==
                     {lat_addr, lat_rt, lat_wt, lat_din});
  assign in_wr    = (write_type != 2'b00);
  assign type_nz  = in_wr || (read_type[1:0] != 2'b00);
  assign in_ram   = (address[31:MEM_ADDR_WIDTH+2] == '0);
  assign accept   = enable && type_nz &&
                    ((state == IDLE) || ((state == DONE) && !tuple_eq));
  assign lat_rd   = (lat_wt == 2'b00) && (lat_rt[1:0] != 2'b00);

  // busy/ready are combinational so a new or changed tuple is seen at once.
  always_comb begin
    busy           = ((state != IDLE) && (state != DONE)) || accept;
    data_out_ready = (state == DONE) && lat_rd && enable && tuple_eq;
  end

`ifdef RAMIO_UART_EN
  localparam int DIV    = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W = $clog2(DIV + 1);

  logic [9:0]        tx_shreg;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  logic              uart_hit;

  assign uart_hit = (address == ADDR_UART_OUT);
`else
  logic uart_hit;
  assign uart_hit = 1'b0;
  assign uart_tx  = 1'b1;
`endif

  // Request FSM: latches tuples, runs the memory handshake and I/O writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lat_addr      <= '0;
      lat_rt        <= '0;
      lat_wt        <= '0;
      lat_din       <= '0;
      data_out      <= '0;
      led           <= 6'b111111;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
`ifdef RAMIO_UART_EN
      uart_tx       <= 1'b1;
      tx_shreg      <= '1;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
`endif
    end else begin
      if (accept) begin
        lat_addr <= address;
        lat_rt   <= read_type;
        lat_wt   <= write_type;
        lat_din  <= data_in;
        if (in_ram) begin
          mem.mem_req  <= 1'b1;
          mem.mem_addr <= address[MEM_ADDR_WIDTH+1:2];
          if (write_type == 2'b11) begin
            mem.mem_we    <= 1'b1;
            mem.mem_wdata <= data_in;
            state         <= MEM_WRITE;
          end else if (in_wr) begin
            mem.mem_we <= 1'b0;
            state      <= RMW_READ;
          end else begin
            mem.mem_we <= 1'b0;
            state      <= MEM_READ;
          end
        end else if (in_wr && (address == ADDR_LEDS)) begin
          led   <= ~data_in[5:0];
          state <= DONE;
        end else if (in_wr && uart_hit) begin
`ifdef RAMIO_UART_EN
          tx_shreg <= {1'b1, data_in[7:0], 1'b0};
          uart_tx  <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          state    <= UART_SEND;
`else
          state    <= DONE;
`endif
        end else begin
          if (!in_wr) data_out <= '0;
          state <= DONE;
        end
      end else begin
        case (state)
          MEM_READ: if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            data_out    <= extend_read(mem.mem_rdata, lat_rt, lat_addr[1:0]);
            state       <= DONE;
          end
          MEM_WRITE: if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            state       <= DONE;
          end
          RMW_READ: if (mem.mem_ack) begin
            mem.mem_req   <= 1'b0;
            mem.mem_wdata <= merge_store(mem.mem_rdata, lat_din, lat_wt,
                                         lat_addr[1:0]);
            state         <= RMW_WRITE;
          end
          // One idle req cycle after the read ack, then the merged write.
          RMW_WRITE: begin
            if (!mem.mem_req) begin
              mem.mem_req <= 1'b1;
              mem.mem_we  <= 1'b1;
            end else if (mem.mem_ack) begin
              mem.mem_req <= 1'b0;
              mem.mem_we  <= 1'b0;
              state       <= DONE;
            end
          end
`ifdef RAMIO_UART_EN
          UART_SEND: begin
            if (baud_cnt == BAUD_W'(DIV - 1)) begin
              baud_cnt <= '0;
              tx_shreg <= {1'b1, tx_shreg[9:1]};
              if (bit_cnt == 4'd9) begin
                uart_tx <= 1'b1;
                state   <= DONE;
              end else begin
                uart_tx <= tx_shreg[1];
                bit_cnt <= bit_cnt + 4'd1;
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
`endif
          IDLE, DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ramio.sv
// tb_ramio: directed self-checking bench for ramio with a req/ack memory
// model whose ack delay is programmable per transaction.
module tb_ramio;
  localparam int MAW = 8;
  localparam int CF  = 1000;
  localparam int BR  = 100;
  localparam int DIV = CF / BR;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  write_type = 2'b00;
  logic [2:0]  read_type = 3'b000;
  logic [31:0] address = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        data_out_ready, busy, uart_tx;
  logic [5:0]  led;

  ramio_if #(.MEM_ADDR_WIDTH(MAW)) mif();

  ramio #(
    .MEM_ADDR_WIDTH(MAW), .CLK_FREQ(CF), .BAUD_RATE(BR),
    .ADDR_LEDS(32'hFFFF_FFFF), .ADDR_UART_OUT(32'hFFFF_FFFE)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .write_type(write_type),
    .read_type(read_type), .address(address), .data_in(data_in),
    .data_out(data_out), .data_out_ready(data_out_ready), .busy(busy),
    .led(led), .uart_tx(uart_tx), .mem(mif.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: acks ack_delay cycles into a request, one-cycle pulse.
  logic [31:0] mem [256];
  int          ack_delay = 0;
  int          rises = 0, rd_acks = 0, wr_acks = 0;
  int          rd_ack_cyc = 0, rise_cyc = 0, ncyc = 0;
  logic [31:0] last_wdata = 32'h0;

  initial begin
    int   wait_cnt;
    logic prev_req;
    wait_cnt = 0;
    prev_req = 1'b0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (mif.mem_req && !prev_req) begin
        rises++;
        rise_cyc = ncyc;
      end
      prev_req = mif.mem_req;
      if (mif.mem_ack) begin
        mif.mem_ack = 1'b0;
        wait_cnt    = 0;
      end else if (mif.mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mif.mem_ack = 1'b1;
          wait_cnt    = 0;
          if (mif.mem_we) begin
            mem[mif.mem_addr] = mif.mem_wdata;
            last_wdata        = mif.mem_wdata;
            wr_acks++;
          end else begin
            mif.mem_rdata = mem[mif.mem_addr];
            rd_acks++;
            rd_ack_cyc = ncyc;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic set_req(input logic [31:0] a, input logic [2:0] rt,
                         input logic [1:0] wt, input logic [31:0] d);
    @(negedge clk);
    address = a; read_type = rt; write_type = wt; data_in = d;
    enable  = 1'b1;
  endtask

  // Counts rising edges until busy drops (edge of acceptance counts as 1).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (!busy) break;
    end
    chk("done_timeout", {31'b0, busy}, 32'h0);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [2:0] rt,
                        input logic [1:0] wt, input logic [31:0] d,
                        output int lat);
    set_req(a, rt, wt, d);
    wait_done(lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat, r0, rd0, wr0, dly, wcnt;
    logic [31:0] pat;
    logic [9:0]  frame;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_ready", {31'b0, data_out_ready}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_led", {26'b0, led}, 32'h3F);
    chk("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
    chk("rst_mem_req", {31'b0, mif.mem_req}, 32'h0);
    chk("rst_mem_we", {31'b0, mif.mem_we}, 32'h0);
    chk("rst_mem_addr", {24'b0, mif.mem_addr}, 32'h0);
    chk("rst_mem_wdata", mif.mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Word write then signed word read, best-case ack
    do_req(32'h10, 3'b000, 2'b11, 32'hDEADBEEF, lat);
    chk("sw_wdata", last_wdata, 32'hDEADBEEF);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    chk("sw_latency", lat, 2);
    do_req(32'h10, 3'b111, 2'b00, 32'h0, lat);
    chk("lw_latency", lat, 2);
    chk("lw_ready", {31'b0, data_out_ready}, 32'h1);
    chk("lw_data", data_out, 32'hDEADBEEF);

    // Sub-word extension over 0x80817F80 at 0x20
    do_req(32'h20, 3'b000, 2'b11, 32'h80817F80, lat);
    do_req(32'h20, 3'b101, 2'b00, 32'h0, lat);
    chk("lb", data_out, 32'hFFFFFF80);
    do_req(32'h20, 3'b001, 2'b00, 32'h0, lat);
    chk("lbu", data_out, 32'h00000080);
    do_req(32'h22, 3'b110, 2'b00, 32'h0, lat);
    chk("lh", data_out, 32'hFFFF8081);
    do_req(32'h22, 3'b010, 2'b00, 32'h0, lat);
    chk("lhu", data_out, 32'h00008081);
    do_req(32'h21, 3'b101, 2'b00, 32'h0, lat);
    chk("lb_lane1", data_out, 32'h0000007F);

    // RMW byte store 0xAA at 0x21 over 0x11223344
    do_req(32'h20, 3'b000, 2'b11, 32'h11223344, lat);
    r0 = rises; rd0 = rd_acks; wr0 = wr_acks;
    do_req(32'h21, 3'b000, 2'b01, 32'h000000AA, lat);
    chk("sb_mem", mem[8], 32'h1122AA44);
    chk("sb_latency", lat, 4);
    chk("sb_reads", rd_acks - rd0, 1);
    chk("sb_writes", wr_acks - wr0, 1);
    chk("sb_req_rises", rises - r0, 2);
    chk("sb_gap", rise_cyc - rd_ack_cyc, 2);
    // Half store 0xBEEF to upper lane at 0x22
    do_req(32'h22, 3'b000, 2'b10, 32'h0000BEEF, lat);
    chk("sh_mem", mem[8], 32'hBEEFAA44);

    // Random ack delays
    for (int i = 0; i < 4; i++) begin
      dly = $urandom_range(0, 7);
      ack_delay = dly;
      pat = 32'h1357_0000 + i * 32'h0101;
      do_req(32'h40 + 4 * i, 3'b000, 2'b11, pat, lat);
      chk("rnd_mem", mem[16 + i], pat);
      do_req(32'h40 + 4 * i, 3'b011, 2'b00, 32'h0, lat);
      chk("rnd_read", data_out, pat);
      chk("rnd_latency", lat, dly + 2);
    end
    ack_delay = 0;

    // Identical read held in DONE: no new memory access
    r0 = rises;
    repeat (3) @(posedge clk);
    #1;
    chk("repeat_ready", {31'b0, data_out_ready}, 32'h1);
    chk("repeat_data", data_out, 32'h1357_0303);
    chk("repeat_no_req", rises - r0, 0);
    // Tuple change in DONE drops ready in the same cycle
    @(negedge clk);
    address = 32'h40;
    #1;
    chk("change_ready", {31'b0, data_out_ready}, 32'h0);
    chk("change_busy", {31'b0, busy}, 32'h1);
    wait_done(lat);
    chk("change_data", data_out, 32'h1357_0000);

    // Unmapped accesses
    r0 = rises;
    do_req(32'h0000_1000, 3'b011, 2'b00, 32'h0, lat);
    chk("unmap_rd_lat", lat, 1);
    chk("unmap_rd_data", data_out, 32'h0);
    chk("unmap_rd_ready", {31'b0, data_out_ready}, 32'h1);
    do_req(32'h0000_1000, 3'b000, 2'b11, 32'h55, lat);
    chk("unmap_wr_lat", lat, 1);
    chk("unmap_no_req", rises - r0, 0);

    // LED register
    do_req(32'hFFFF_FFFF, 3'b000, 2'b01, 32'h05, lat);
    chk("led_lat", lat, 1);
    chk("led_val", {26'b0, led}, 32'h3A);

    // UART register
`ifdef RAMIO_UART_EN
    frame = 10'b1_0100_0001_0;
    wcnt = -1;
    set_req(32'hFFFF_FFFE, 3'b000, 2'b01, 32'h41);
    for (int c = 1; c <= 10 * DIV + 5; c++) begin
      @(posedge clk);
      #1;
      if (((c % DIV) == DIV / 2) && ((c / DIV) < 10)) begin
        chk("uart_bit", {31'b0, uart_tx}, {31'b0, frame[c / DIV]});
        chk("uart_busy", {31'b0, busy}, 32'h1);
      end
      if (!busy && wcnt < 0) wcnt = c;
    end
    chk("uart_done_edge", wcnt, 10 * DIV + 1);
    chk("uart_idle", {31'b0, uart_tx}, 32'h1);
`else
    do_req(32'hFFFF_FFFE, 3'b000, 2'b01, 32'h41, lat);
    chk("uart_off_lat", lat, 1);
    chk("uart_off_tx", {31'b0, uart_tx}, 32'h1);
`endif

    // Reset during RMW_WRITE
    ack_delay = 5;
    set_req(32'h25, 3'b000, 2'b01, 32'h77);
    wcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (mif.mem_req && mif.mem_we) break;
      wcnt++;
    end
    chk("rmw_write_seen", {31'b0, mif.mem_req & mif.mem_we}, 32'h1);
    #2;
    rst = 1'b1;
    enable = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, mif.mem_req}, 32'h0);
    chk("mid_rst_we", {31'b0, mif.mem_we}, 32'h0);
    chk("mid_rst_addr", {24'b0, mif.mem_addr}, 32'h0);
    chk("mid_rst_wdata", mif.mem_wdata, 32'h0);
    chk("mid_rst_led", {26'b0, led}, 32'h3F);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_data", data_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    do_req(32'h10, 3'b011, 2'b00, 32'h0, lat);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_data", data_out, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
